// File: rtl/axis_wrr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_wrr_arbiter_pkg
// Purpose  : Shared constants and helpers for the weighted round-robin
//            arbiter: FSM state encoding and a modulo increment helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package axis_wrr_arbiter_pkg;

  localparam int ST_W = 1;
  localparam logic [ST_W-1:0] ST_IDLE = 1'b0;  // no grant outstanding
  localparam logic [ST_W-1:0] ST_BUSY = 1'b1;  // grant held until tlast ack

  // (v + 1) mod n for 0 <= v < n, without a divider.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_wrr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_wrr_arbiter_if
// Purpose  : Request/grant bundle between the requesting stream ports plus
//            weight CSRs (master) and the weighted round-robin arbiter (slave).
// Ports    : request, acknowledge, weight  -> from master to slave
//            grant, grant_valid, grant_encoded, round_reload -> slave to master
// Revision : 1.0 - initial release
// ============================================================================
interface axis_wrr_arbiter_if #(
  parameter int PORTS        = 4,
  parameter int WEIGHT_WIDTH = 4
);
  import axis_wrr_arbiter_pkg::*;

  localparam int CL_PORTS = $clog2(PORTS);

  logic [PORTS-1:0]              request;
  logic [PORTS-1:0]              acknowledge;
  logic [PORTS*WEIGHT_WIDTH-1:0] weight;
  logic [PORTS-1:0]              grant;
  logic                          grant_valid;
  logic [CL_PORTS-1:0]           grant_encoded;
  logic                          round_reload;

  modport master (
    output request, acknowledge, weight,
    input  grant, grant_valid, grant_encoded, round_reload
  );

  modport slave (
    input  request, acknowledge, weight,
    output grant, grant_valid, grant_encoded, round_reload
  );

endinterface
`default_nettype wire

// File: rtl/axis_wrr_arbiter_rr_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_encoder
// Purpose  : Combinational round-robin priority encoder. Finds the first set
//            request bit searching start_i, start_i+1, ... modulo PORTS.
// Ports    : req_i     - request vector
//            start_i   - index searched first
//            valid_o   - any request set
//            onehot_o  - one-hot winner (zero when !valid_o)
//            encoded_o - binary winner index
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_encoder #(
  parameter int PORTS = 4,
  localparam int CL_PORTS = $clog2(PORTS)
) (
  input  logic [PORTS-1:0]    req_i,
  input  logic [CL_PORTS-1:0] start_i,
  output logic                valid_o,
  output logic [PORTS-1:0]    onehot_o,
  output logic [CL_PORTS-1:0] encoded_o
);

  logic [PORTS-1:0] w_rot;
  int               w_k;
  int               w_idx;

  // Rotate so that start_i lands on bit 0, then a plain lowest-bit search
  // gives round-robin order; the winner is rotated back afterwards.
  always_comb begin
    w_rot = '0;
    for (int k = 0; k < PORTS; k++) begin
      w_rot[k] = req_i[(int'(start_i) + k) % PORTS];
    end
  end

  always_comb begin
    w_k = 0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_k = k;
      end
    end
    w_idx     = (int'(start_i) + w_k) % PORTS;
    valid_o   = |w_rot;
    encoded_o = CL_PORTS'(w_idx);
    onehot_o  = valid_o ? (PORTS'(1) << w_idx) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/axis_wrr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axis_wrr_arbiter
// Purpose  : Packet-aware weighted round-robin arbiter. Each port may win up
//            to weight[i] whole packets per round; the grant is held from the
//            first beat until the tlast acknowledge of the granted port.
// Ports    : clk, rst (synchronous, active-high)
//            bus (slave modport): request, acknowledge, weight in;
//            grant, grant_valid, grant_encoded, round_reload out (registered)
// Revision : 1.0 - initial release
// ============================================================================
module axis_wrr_arbiter
  import axis_wrr_arbiter_pkg::*;
#(
  parameter int PORTS        = 4,
  parameter int WEIGHT_WIDTH = 4,
  localparam int CL_PORTS    = $clog2(PORTS)
) (
  input  logic              clk,
  input  logic              rst,
  axis_wrr_arbiter_if.slave bus
);

  logic [ST_W-1:0]                    state_q, state_d;
  logic [PORTS-1:0][WEIGHT_WIDTH-1:0] credit_q, credit_d;
  logic [CL_PORTS-1:0]                ptr_q, ptr_d;
  logic [PORTS-1:0]                   grant_q, grant_d;
  logic                               valid_q, valid_d;
  logic [CL_PORTS-1:0]                enc_q, enc_d;
  logic                               reload_q, reload_d;

  logic [PORTS-1:0]        w_weight_nz;
  logic [PORTS-1:0]        w_elig;
  logic                    w_win_valid;
  logic [PORTS-1:0]        w_win_onehot;
  logic [CL_PORTS-1:0]     w_win_enc;
  logic                    w_ack_g;
  logic [WEIGHT_WIDTH-1:0] w_cred_dec;

  // Live weight gates eligibility so writing 0 masks a port at once.
  for (genvar i = 0; i < PORTS; i++) begin : g_elig
    assign w_weight_nz[i] = |bus.weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    assign w_elig[i]      = bus.request[i] && (credit_q[i] != '0) && w_weight_nz[i];
  end

  rr_priority_encoder #(.PORTS(PORTS)) u_prio (
    .req_i    (w_elig),
    .start_i  (ptr_q),
    .valid_o  (w_win_valid),
    .onehot_o (w_win_onehot),
    .encoded_o(w_win_enc)
  );

  // Only the granted port's tlast ends the packet.
  assign w_ack_g    = bus.acknowledge[enc_q];
  assign w_cred_dec = (credit_q[enc_q] == '0) ? '0 : credit_q[enc_q] - 1'b1;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      ptr_q    <= '0;
      grant_q  <= '0;
      valid_q  <= 1'b0;
      enc_q    <= '0;
      reload_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      valid_q  <= valid_d;
      enc_q    <= enc_d;
      reload_q <= reload_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_win_valid) state_d = ST_BUSY;
      ST_BUSY: if (w_ack_g)     state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    grant_d  = grant_q;
    valid_d  = valid_q;
    enc_d    = enc_q;
    reload_d = 1'b0;
    credit_d = credit_q;
    ptr_d    = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (w_win_valid) begin
          grant_d = w_win_onehot;
          enc_d   = w_win_enc;
          valid_d = 1'b1;
        end else if (|(bus.request & w_weight_nz)) begin
          // Somebody wants service but every requester is out of credit:
          // start a new round. Arbitration resumes on the following cycle.
          reload_d = 1'b1;
          for (int i = 0; i < PORTS; i++) begin
            credit_d[i] = bus.weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
          end
        end
      end
      ST_BUSY: begin
        if (w_ack_g) begin
          credit_d[enc_q] = w_cred_dec;
          // A port with credit left keeps priority so it can win again.
          ptr_d   = (w_cred_dec == '0) ? CL_PORTS'(wrap_inc(int'(enc_q), PORTS)) : enc_q;
          grant_d = '0;
          valid_d = 1'b0;
        end
      end
      default: begin
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign bus.grant         = grant_q;
  assign bus.grant_valid   = valid_q;
  assign bus.grant_encoded = enc_q;
  assign bus.round_reload  = reload_q;

endmodule
`default_nettype wire
